// File: rtl/psum_drain_collector_if.sv
// Handshake bundle between the PE column output, the drain collector and the writeback path.
// Signal names keep their collector-side i_/o_ prefixes so both ends read the same.
interface psum_drain_collector_if #(
  parameter int BW2 = 16,
  parameter int OW  = 16,
  parameter int CW  = 3
);
  logic                  i_valid;
  logic signed [BW2-1:0] i_psum;
  logic                  o_in_ready;
  logic                  i_clear;
  logic                  o_valid;
  logic signed [OW-1:0]  o_data;
  logic                  i_ready;
  logic [CW-1:0]         o_count;
  logic                  o_sat;

  modport slave (
    input  i_valid, i_psum, i_clear, i_ready,
    output o_in_ready, o_valid, o_data, o_count, o_sat
  );

  modport master (
    output i_valid, i_psum, i_clear, i_ready,
    input  o_in_ready, o_valid, o_data, o_count, o_sat
  );
endinterface

// File: rtl/psum_drain_collector.sv
// Accumulates K psum beats per result, saturates to OW bits and queues results in a small FIFO.
// Optional macro DRAIN_ROUND_SHIFT_EN adds a round-half-up arithmetic right shift by SHIFT before saturation.
module psum_drain_collector #(
  parameter int BW2   = 16,
  parameter int AW    = 24,
  parameter int OW    = 16,
  parameter int K     = 4,
  parameter int DEPTH = 4,
  parameter int SHIFT = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  psum_drain_collector_if.slave   bus
);
  localparam int CNT_W = (K > 1) ? $clog2(K) : 1;
  localparam int PW    = $clog2(DEPTH);
  localparam int CW    = $clog2(DEPTH + 1);
`ifdef DRAIN_ROUND_SHIFT_EN
  localparam int RW    = AW + 1;
  localparam int RND   = (SHIFT == 0) ? 0 : (1 << ((SHIFT == 0) ? 0 : SHIFT - 1));
`else
  localparam int RW    = AW;
`endif
  localparam logic signed [RW-1:0] SAT_MAX = {{(RW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [RW-1:0] SAT_MIN = ~SAT_MAX;

  if (K < 1)                              begin : g_bad_k     $error("K must be >= 1");                       end
  if (DEPTH < 2 || (DEPTH & (DEPTH-1)) != 0) begin : g_bad_depth $error("DEPTH must be a power of two >= 2"); end
  if (AW < BW2 + $clog2(K) || AW < OW)    begin : g_bad_aw    $error("AW too narrow");                        end
  if (SHIFT < 0)                          begin : g_bad_shift $error("SHIFT must be >= 0");                   end

  logic [CNT_W-1:0]     cnt;
  logic signed [AW-1:0] acc;
  logic [PW-1:0]        wr_ptr, rd_ptr;
  logic [CW-1:0]        count;
  logic                 sat;
  logic signed [OW-1:0] mem [DEPTH];

  logic                 full, in_ready, accept, last, push, pop;
  logic [CNT_W-1:0]     base_cnt;
  logic signed [AW-1:0] psum_ext, acc_base, acc_sum;
  logic signed [RW-1:0] res;
  logic signed [OW-1:0] sat_val;
  logic                 clamped;

  // A clear in the same cycle as a beat makes that beat the first of a fresh group.
  assign base_cnt = bus.i_clear ? '0 : cnt;
  assign last     = (base_cnt == CNT_W'(K - 1));
  assign full     = (count == CW'(DEPTH));
  assign in_ready = !((cnt == CNT_W'(K - 1)) && full);
  assign accept   = bus.i_valid && in_ready;
  assign push     = accept && last;
  assign pop      = (count != '0) && bus.i_ready;

  assign psum_ext = {{(AW-BW2){bus.i_psum[BW2-1]}}, bus.i_psum};
  assign acc_base = (base_cnt == '0) ? '0 : acc;
  assign acc_sum  = acc_base + psum_ext;

`ifdef DRAIN_ROUND_SHIFT_EN
  logic signed [RW-1:0] rounded;
  // One guard bit keeps the rounding add from wrapping at the top of the accumulator range.
  assign rounded = {acc_sum[AW-1], acc_sum} + RW'(RND);
  assign res     = rounded >>> SHIFT;
`else
  assign res     = acc_sum;
`endif

  always_comb begin
    clamped = 1'b1;
    sat_val = res[OW-1:0];
    if (res > SAT_MAX)      sat_val = SAT_MAX[OW-1:0];
    else if (res < SAT_MIN) sat_val = SAT_MIN[OW-1:0];
    else                    clamped = 1'b0;
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      cnt    <= '0;
      acc    <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      sat    <= 1'b0;
    end else begin
      if (accept) begin
        acc <= acc_sum;
        cnt <= last ? '0 : base_cnt + CNT_W'(1);
      end else if (bus.i_clear) begin
        cnt <= '0;
      end
      if (push) begin
        wr_ptr <= wr_ptr + PW'(1);
        if (clamped) sat <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + PW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

  // NOTE: result storage is not reset; o_data is forced to zero whenever the FIFO is empty.
  always_ff @(posedge i_clk) begin
    if (push) mem[wr_ptr] <= sat_val;
  end

  assign bus.o_in_ready = in_ready;
  assign bus.o_valid    = (count != '0);
  assign bus.o_data     = (count != '0) ? mem[rd_ptr] : '0;
  assign bus.o_count    = count;
  assign bus.o_sat      = sat;
endmodule

// File: tb/tb_psum_drain_collector.sv
// Self-checking bench for psum_drain_collector: vector table, hand-written corner sequences and
// randomized traffic against a queue-based reference model.
module tb_psum_drain_collector;
  localparam int BW2 = 16, AW = 24, OW = 16, K = 4, DEPTH = 4, SHIFT = 2;
  localparam int CW = $clog2(DEPTH + 1);

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  psum_drain_collector_if #(.BW2(BW2), .OW(OW), .CW(CW)) bus ();

  psum_drain_collector #(
    .BW2(BW2), .AW(AW), .OW(OW), .K(K), .DEPTH(DEPTH), .SHIFT(SHIFT)
  ) dut (
    .i_clk (clk),
    .i_rst (rst),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input longint act, input longint exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Final value a group sum should produce at the output.
  function automatic longint shaped(input longint s);
`ifdef DRAIN_ROUND_SHIFT_EN
    longint r = (SHIFT == 0) ? 0 : (longint'(1) << (SHIFT - 1));
    return (s + r) >>> SHIFT;
`else
    return s;
`endif
  endfunction

  function automatic longint fin(input longint s);
    longint v = shaped(s);
    if (v > 32767)  return 32767;
    if (v < -32768) return -32768;
    return v;
  endfunction

  function automatic bit clamps(input longint s);
    return fin(s) != shaped(s);
  endfunction

  task automatic drive(input bit vld, input int ps, input bit clr, input bit rdy);
    bus.i_valid = vld;
    bus.i_psum  = BW2'(ps);
    bus.i_clear = clr;
    bus.i_ready = rdy;
  endtask

  task automatic cycle();
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic chk_out(input string tag, input bit ev, input longint ed, input int ec,
                         input bit es, input bit er);
    check({tag, ".valid"},    longint'(bus.o_valid),    longint'(ev));
    check({tag, ".data"},     longint'(bus.o_data),     ed);
    check({tag, ".count"},    longint'(bus.o_count),    longint'(ec));
    check({tag, ".sat"},      longint'(bus.o_sat),      longint'(es));
    check({tag, ".in_ready"}, longint'(bus.o_in_ready), longint'(er));
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    bit vld; int psum; bit clr; bit rdy;
    bit ev; longint ed; int ec; bit es; bit er;
  } vec_t;
  vec_t tbl[$];

  function automatic void add(input bit vld, input int ps, input bit clr, input bit rdy,
                              input bit ev, input longint ed, input int ec, input bit es);
    vec_t v;
    v.vld = vld; v.psum = ps; v.clr = clr; v.rdy = rdy;
    v.ev = ev; v.ed = ed; v.ec = ec; v.es = es; v.er = 1'b1;
    tbl.push_back(v);
  endfunction

  function automatic void build_table();
    bit s = 1'b0;
    // basic group with downstream always ready
    add(1, 10, 0, 1, 0, 0, 0, s);
    add(1, 20, 0, 1, 0, 0, 0, s);
    add(1, -5, 0, 1, 0, 0, 0, s);
    s |= clamps(28);
    add(1, 3, 0, 1, 1, fin(28), 1, s);
    add(0, 0, 0, 1, 0, 0, 0, s);
    // positive then negative saturation
    for (int i = 0; i < 3; i++) add(1, 20000, 0, 1, 0, 0, 0, s);
    s |= clamps(80000);
    add(1, 20000, 0, 1, 1, fin(80000), 1, s);
    for (int i = 0; i < 3; i++) add(1, -20000, 0, 1, 0, 0, 0, s);
    s |= clamps(-80000);
    add(1, -20000, 0, 1, 1, fin(-80000), 1, s);
    add(0, 0, 0, 1, 0, 0, 0, s);
    // clear alone discards the partial group
    add(1, 7, 0, 1, 0, 0, 0, s);
    add(1, 7, 0, 1, 0, 0, 0, s);
    add(0, 0, 1, 1, 0, 0, 0, s);
    for (int i = 0; i < 3; i++) add(1, 1, 0, 1, 0, 0, 0, s);
    add(1, 1, 0, 1, 1, fin(4), 1, s);
    add(0, 0, 0, 1, 0, 0, 0, s);
    // clear together with a beat restarts the group on that beat
    add(1, 7, 0, 1, 0, 0, 0, s);
    add(1, 7, 0, 1, 0, 0, 0, s);
    add(1, 5, 1, 1, 0, 0, 0, s);
    add(1, 1, 0, 1, 0, 0, 0, s);
    add(1, 1, 0, 1, 0, 0, 0, s);
    add(1, 1, 0, 1, 1, fin(8), 1, s);
    add(0, 0, 0, 1, 0, 0, 0, s);
  endfunction

  // ---------------- reference model ----------------
  int     m_cnt;
  longint m_acc;
  longint m_q[$];
  bit     m_sat;

  function automatic void model_reset();
    m_cnt = 0; m_acc = 0; m_q.delete(); m_sat = 1'b0;
  endfunction

  function automatic bit model_ready();
    return !(m_cnt == K - 1 && m_q.size() == DEPTH);
  endfunction

  function automatic void model_step(input bit vld, input int ps, input bit clr, input bit rdy);
    bit take = vld && model_ready();
    logic signed [AW-1:0] w;
    if (m_q.size() > 0 && rdy) void'(m_q.pop_front());
    if (clr) m_cnt = 0;
    if (take) begin
      m_acc = (m_cnt == 0) ? longint'(ps) : m_acc + ps;
      w = m_acc[AW-1:0];
      m_acc = w;
      if (m_cnt == K - 1) begin
        m_q.push_back(fin(m_acc));
        if (clamps(m_acc)) m_sat = 1'b1;
      end
      m_cnt = (m_cnt + 1) % K;
    end
  endfunction

  task automatic do_reset();
    @(negedge clk);
    drive(0, 0, 0, 0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
  endtask

  initial begin
    drive(0, 0, 0, 0);
    #2;
    chk_out("reset", 0, 0, 0, 0, 1);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    check("release.in_ready", longint'(bus.o_in_ready), 1);

    // table-driven vectors
    build_table();
    foreach (tbl[i]) begin
      drive(tbl[i].vld, tbl[i].psum, tbl[i].clr, tbl[i].rdy);
      cycle();
      chk_out($sformatf("vec%0d", i), tbl[i].ev, tbl[i].ed, tbl[i].ec, tbl[i].es, tbl[i].er);
    end

    // full FIFO with a stalled final beat
    do_reset();
    for (int i = 0; i < 4 * K; i++) begin
      drive(1, 1, 0, 0);
      cycle();
    end
    chk_out("full.after4", 1, fin(4), 4, 0, 1);
    for (int i = 0; i < K - 1; i++) begin
      drive(1, 1, 0, 0);
      cycle();
    end
    chk_out("full.group5_partial", 1, fin(4), 4, 0, 0);
    drive(1, 1, 0, 0);
    cycle();
    chk_out("full.stalled", 1, fin(4), 4, 0, 0);
    drive(1, 1, 0, 1);
    check("full.pop_head", longint'(bus.o_data), fin(4));
    cycle();
    chk_out("full.after_pop", 1, fin(4), 3, 0, 1);
    drive(1, 1, 0, 0);
    cycle();
    chk_out("full.stall_taken", 1, fin(4), 4, 0, 1);
    drive(0, 0, 0, 1);
    for (int i = 0; i < 4; i++) begin
      check($sformatf("drain%0d.data", i), longint'(bus.o_data), fin(4));
      cycle();
    end
    chk_out("drained", 0, 0, 0, 0, 1);

    // asynchronous reset mid-group with results buffered
    for (int i = 0; i < 4 * K; i++) begin
      drive(1, 30000, 0, 0);
      cycle();
      if (i == 2 * K - 1) break;
    end
    for (int i = 0; i < 2; i++) begin
      drive(1, 1, 0, 0);
      cycle();
    end
    check("pre_rst.count", longint'(bus.o_count), 2);
    check("pre_rst.sat", longint'(bus.o_sat), 1);
    drive(0, 0, 0, 0);
    #1 rst = 1'b1;
    #1;
    chk_out("async_rst", 0, 0, 0, 0, 1);
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < K; i++) begin
      drive(1, 2, 0, 1);
      cycle();
    end
    chk_out("post_rst", 1, fin(8), 1, 0, 1);
    drive(0, 0, 0, 1);
    cycle();

`ifdef DRAIN_ROUND_SHIFT_EN
    begin
      int grp [3][4] = '{'{4, 3, 2, 1}, '{-4, -3, -2, -1}, '{1, 2, 3, 0}};
      int want [3]   = '{3, -2, 2};
      for (int g = 0; g < 3; g++) begin
        for (int b = 0; b < 4; b++) begin
          drive(1, grp[g][b], 0, 1);
          cycle();
        end
        check($sformatf("round%0d.data", g), longint'(bus.o_data), want[g]);
        drive(0, 0, 0, 1);
        cycle();
      end
    end
`endif

    // randomized traffic against the reference model
    do_reset();
    model_reset();
    for (int n = 0; n < 400; n++) begin
      bit vld, clr, rdy;
      int ps;
      check($sformatf("rnd%0d.valid", n), longint'(bus.o_valid), longint'(m_q.size() != 0));
      check($sformatf("rnd%0d.data", n), longint'(bus.o_data), (m_q.size() != 0) ? m_q[0] : 0);
      check($sformatf("rnd%0d.count", n), longint'(bus.o_count), longint'(m_q.size()));
      check($sformatf("rnd%0d.sat", n), longint'(bus.o_sat), longint'(m_sat));
      check($sformatf("rnd%0d.in_ready", n), longint'(bus.o_in_ready), longint'(model_ready()));
      vld = ($urandom_range(0, 3) != 0);
      clr = ($urandom_range(0, 15) == 0);
      rdy = ($urandom_range(0, 2) == 0);
      if ($urandom_range(0, 3) == 0) ps = int'($urandom_range(0, 65535)) - 32768;
      else                           ps = int'($urandom_range(0, 200)) - 100;
      drive(vld, ps, clr, rdy);
      model_step(vld, ps, clr, rdy);
      cycle();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
